// File: rtl/fifo_flagged.sv
// Single-clock flagged FIFO for the buff_uart TX/RX byte path.
// Optional FIFO_FWFT_EN selects first-word fall-through read data.
module fifo_flagged #(
  parameter int WIDTH    = 8,
  parameter int LENGTH   = 4,
  parameter int AF_LEVEL = 3,
  parameter int AE_LEVEL = 1
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         write_enable,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         read_enable,
  output logic [WIDTH-1:0]             data_out,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(LENGTH+1)-1:0]  count,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         clear_errors
);

  localparam int CW = $clog2(LENGTH+1);
  localparam int PW = $clog2(LENGTH);

  localparam logic [PW-1:0] LAST = PW'(LENGTH-1);
  localparam logic [CW-1:0] LEN_C = CW'(LENGTH);
  localparam logic [CW-1:0] AF_C  = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C  = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [LENGTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             rd_acc;
  logic             wr_acc;
  logic [CW-1:0]    cnt_nxt;

  // A read frees a slot, so a full FIFO still takes a same-cycle write.
  assign rd_acc = read_enable && !empty;
  assign wr_acc = write_enable && (!full || rd_acc);

  // Depth need not be a power of two, so wrap by compare.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Next occupancy from the accepted operations.
  always_comb begin
    cnt_nxt = count;
    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_nxt = count + CW'(1);
      2'b01:   cnt_nxt = count - CW'(1);
      default: cnt_nxt = count;
    endcase
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  // Read and write pointers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Count and its derived flags, all registered together.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      count        <= cnt_nxt;
      full         <= (cnt_nxt == LEN_C);
      empty        <= (cnt_nxt == '0);
      almost_full  <= (cnt_nxt >= AF_C);
      almost_empty <= (cnt_nxt <= AE_C);
    end
  end

  // Sticky error flags; a new error beats a clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_enable && !wr_acc) overflow <= 1'b1;
      else if (clear_errors)       overflow <= 1'b0;
      if (read_enable && !rd_acc)  underflow <= 1'b1;
      else if (clear_errors)       underflow <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word shown directly; zero while nothing is stored.
  always_comb begin
    data_out = '0;
    if (!empty) data_out = mem[rd_ptr];
  end
`else
  // Registered read data, held when no read is accepted.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)     data_out <= '0;
    else if (rd_acc) data_out <= mem[rd_ptr];
  end
`endif

endmodule

// File: tb/tb_fifo_flagged.sv
// Randomised scoreboard bench for fifo_flagged, LENGTH 4 and 5.
// A queue-based reference model predicts every cycle's outputs.
module tb_fifo_flagged;

  logic       clock  = 1'b0;
  logic       resetn = 1'b0;
  logic       we     = 1'b0;
  logic       rd     = 1'b0;
  logic       clr    = 1'b0;
  logic [7:0] din    = '0;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] dout;
    int         cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       unf;
  } exp_t;

  task automatic chk(input string name, input int len,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s L=%0d t=%0t got %0h want %0h",
               name, len, $time, act, exp);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int L = 4 + k;

    logic [7:0]               dout;
    logic                     full, empty, af, ae, ovf, unf;
    logic [$clog2(L+1)-1:0]   cnt;

    fifo_flagged #(
      .WIDTH(8), .LENGTH(L), .AF_LEVEL(3), .AE_LEVEL(1)
    ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .write_enable(we),
      .data_in     (din),
      .read_enable (rd),
      .data_out    (dout),
      .full        (full),
      .empty       (empty),
      .almost_full (af),
      .almost_empty(ae),
      .count       (cnt),
      .overflow    (ovf),
      .underflow   (unf),
      .clear_errors(clr)
    );

    logic [7:0] q[$];
    logic [7:0] last  = '0;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    exp_t       exp_q[$];

    // Reference model: pushes the expected post-edge state each cycle.
    always @(posedge clock) begin : model
      exp_t e;
      bit   ra, wa;
      if (!resetn) begin
        q.delete();
        last  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end else begin
        ra = rd && (q.size() > 0);
        wa = we && ((q.size() < L) || ra);
        if (ra) last = q.pop_front();
        if (wa) q.push_back(din);
        if (we && !wa) m_ovf = 1'b1;
        else if (clr)  m_ovf = 1'b0;
        if (rd && !ra) m_unf = 1'b1;
        else if (clr)  m_unf = 1'b0;
      end
      e.cnt   = q.size();
      e.full  = (q.size() == L);
      e.empty = (q.size() == 0);
      e.af    = (q.size() >= 3);
      e.ae    = (q.size() <= 1);
      e.ovf   = m_ovf;
      e.unf   = m_unf;
`ifdef FIFO_FWFT_EN
      e.dout  = (q.size() > 0) ? q[0] : 8'h00;
`else
      e.dout  = last;
`endif
      exp_q.push_back(e);
    end

    // Monitor: compares DUT outputs just after each edge.
    always @(posedge clock) begin : mon
      exp_t e;
      #1;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard L=%0d empty at t=%0t", L, $time);
      end else begin
        e = exp_q.pop_front();
        chk("data_out",     L, 32'(dout),  32'(e.dout));
        chk("count",        L, 32'(cnt),   32'(e.cnt));
        chk("full",         L, 32'(full),  32'(e.full));
        chk("empty",        L, 32'(empty), 32'(e.empty));
        chk("almost_full",  L, 32'(af),    32'(e.af));
        chk("almost_empty", L, 32'(ae),    32'(e.ae));
        chk("overflow",     L, 32'(ovf),   32'(e.ovf));
        chk("underflow",    L, 32'(unf),   32'(e.unf));
      end
    end

    // Asynchronous reset must take effect without a clock edge.
    always @(negedge resetn) begin
      #1;
      chk("rst_data_out", L, 32'(dout),  32'h0);
      chk("rst_count",    L, 32'(cnt),   32'h0);
      chk("rst_full",     L, 32'(full),  32'h0);
      chk("rst_empty",    L, 32'(empty), 32'h1);
      chk("rst_af",       L, 32'(af),    32'h0);
      chk("rst_ae",       L, 32'(ae),    32'h1);
      chk("rst_ovf",      L, 32'(ovf),   32'h0);
      chk("rst_unf",      L, 32'(unf),   32'h0);
    end
  end

  task automatic drive(input logic w, input logic r,
                       input logic [7:0] d, input logic c);
    @(negedge clock);
    we  = w;
    rd  = r;
    din = d;
    clr = c;
  endtask

  initial begin
    int pw;
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(17 * (i + 1)), 1'b0);
    drive(1'b1, 1'b0, 8'h55, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    repeat (5) drive(1'b0, 1'b1, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
    drive(1'b1, 1'b1, 8'h66, 1'b0);
    repeat (6) drive(1'b0, 1'b1, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 8'($urandom), 1'b0);
      drive(1'b0, 1'b1, 8'h00, 1'b0);
    end

    for (int i = 0; i < 600; i++) begin
      pw = ((i / 40) % 2 != 0) ? 75 : 25;
      drive($urandom_range(0, 99) < pw,
            $urandom_range(0, 99) < (100 - pw),
            8'($urandom),
            $urandom_range(0, 15) == 0);
    end

    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b1, 1'b0, 8'h3C, 1'b0);
    drive(1'b1, 1'b0, 8'hC3, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge clock);
    #3 resetn = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;

    drive(1'b1, 1'b0, 8'hA5, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 8'h00, 1'b0);

    for (int i = 0; i < 200; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            8'($urandom), $urandom_range(0, 7) == 0);
    end

    drive(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
